// File: rtl/spi_slave_reg_ctrl.sv
// Byte-level transaction sequencer behind an SPI slave shifter.
// Decodes a command byte per ss-low frame and sequences burst register writes/reads.
module spi_slave_reg_ctrl #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             ss,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  output logic             dir,
  output logic [7:0]       tx_byte,
  output logic [6:0]       reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr,
  output logic             reg_rd,
  input  logic [7:0]       reg_rdata,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             cmd_err
);

  localparam int unsigned ADDR_W = 7;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    BAD  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_legal;
  logic              byte_in;
  logic [ADDR_W-1:0] addr_next;

  assign cmd_addr  = rx_byte[6:0];
  assign cmd_legal = ({1'b0, cmd_addr} < 8'(NUM_REGS));
  assign byte_in   = rx_valid && !ss;
  assign addr_next = (reg_addr == LAST_ADDR) ? '0 : reg_addr + ADDR_W'(1);

  // Frame state: reset and ss-high both force IDLE asynchronously.
  always_ff @(posedge sclk or negedge reset_n or posedge ss) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (ss) begin
      state <= IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          if (!cmd_legal)     state <= BAD;
          else if (rx_byte[7]) state <= WR;
          else                state <= RD;
        end
        default: state <= state;
      endcase
    end
  end

  // Address, frame counter and error flag survive frame ends; only reset clears them.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      reg_addr  <= '0;
      frame_cnt <= '0;
      cmd_err   <= 1'b0;
    end else if (byte_in) begin
      case (state)
        IDLE: begin
          frame_cnt <= frame_cnt + CNT_W'(1);
          if (cmd_legal) reg_addr <= cmd_addr;
          else           cmd_err  <= 1'b1;
        end
        WR, RD:  reg_addr <= addr_next;
        default: reg_addr <= reg_addr;
      endcase
    end
  end

  // Shifter and register-file handshake; read data passes straight through for zero latency.
  always_comb begin
    dir       = 1'b1;
    tx_byte   = 8'hFF;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    reg_wdata = rx_byte;
    case (state)
      WR: reg_wr = byte_in;
      RD: begin
        dir     = 1'b0;
        tx_byte = reg_rdata;
        reg_rd  = byte_in;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/spi_slave_reg_ctrl.md
Name: spi_slave_reg_ctrl

Overview:
- Byte-level transaction sequencer behind the SPI slave shifter, clocked by sclk.
- Decodes the first byte of each ss-low frame as a command (R/W + 7-bit address) and sequences the following bytes as burst register writes or reads.
- Drives the shifter's direction select and transmit byte; drives a simple register-file port.

Parameters:
- NUM_REGS, 16, number of implemented registers; legal addresses 0..NUM_REGS-1 (1..128).
- CNT_W, 8, width of frame_cnt.

Ports:
- sclk  in  1  SPI clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ss  in  1  slave select, active low; high = frame inactive.
- rx_valid  in  1  one-sclk pulse from shifter: rx_byte holds a complete received byte.
- rx_byte  in  8  received byte.
- dir  out  1  shifter direction: 1 = receive (MOSI capture), 0 = transmit.
- tx_byte  out  8  byte for the shifter to transmit; stable from the edge that ends the previous byte.
- reg_addr  out  7  register-file address (registered).
- reg_wdata  out  8  write data (= rx_byte).
- reg_wr  out  1  write strobe; register file writes on the posedge where it is high.
- reg_rd  out  1  read-consume strobe (for read-to-clear registers).
- reg_rdata  in  8  asynchronous read data for reg_addr.
- frame_cnt  out  CNT_W  count of accepted command bytes; wraps to 0.
- cmd_err  out  1  sticky illegal-address flag.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, reg_addr=0, frame_cnt=0, cmd_err=0.
- Frame clear: ss=1 asynchronously forces state=IDLE. reg_addr, frame_cnt and cmd_err hold.
- Command byte: bit7 = 1 write, 0 read; bits6:0 = address.
- States: IDLE, WR, RD, BAD.
- IDLE, on rx_valid with ss=0:
  - addr < NUM_REGS: reg_addr <= addr; next state = WR if bit7 else RD.
  - addr >= NUM_REGS: cmd_err <= 1; next state = BAD.
  - Either case: frame_cnt <= frame_cnt+1.
- WR, on rx_valid:
  - reg_wr=1 same cycle, reg_wdata=rx_byte, write at current reg_addr.
  - reg_addr <= (reg_addr==NUM_REGS-1) ? 0 : reg_addr+1.
- RD, on rx_valid:
  - reg_rd=1 same cycle.
  - reg_addr advances with the same wrap rule.
  - tx_byte follows reg_rdata combinationally, so it is valid immediately after the command edge (zero-cycle latency to first data byte).
- BAD: no strobes; tx_byte=8'hFF; remains in BAD until ss=1.
- Combinational outputs:
  - dir = 0 only in RD, else 1.
  - tx_byte = reg_rdata in RD, else 8'hFF.
  - reg_wr, reg_rd = 0 whenever ss=1, regardless of rx_valid.
- ss rising mid-byte (rx_valid never pulses): no write, no address change for that byte.
- reset_n low mid-frame aborts immediately; no strobes while reset is active.
- Unbounded burst length; address wrap is silent (no error).
- Zero-length frame (command only): frame_cnt increments, no strobes.

Test Plan:
- Write burst: frame ss=0, bytes 0x83,0xA1,0xB2 -> reg_wr pulses at addr 3 (0xA1) and 4 (0xB2); dir=1 throughout; reg_addr=5 after; frame_cnt=1.
- Read burst: regs[5]=0x5A, regs[6]=0x6B; frame bytes 0x05,x,x -> dir=0 after cmd edge; tx_byte=0x5A then 0x6B; two reg_rd pulses; reg_wr never high.
- Wrap: NUM_REGS=16, write 0x8F then 3 data bytes -> writes at 15, 0, 1.
- Illegal address: cmd 0x92 (addr 18) + 2 bytes -> cmd_err=1, no reg_wr; tx_byte=0xFF. Next legal frame proceeds normally; cmd_err stays 1.
- Abort: cmd 0x82, ss=1 after 4 bits of data -> no reg_wr; state IDLE. Next frame's first byte is decoded as a command.
- Async reset mid-read burst: reset_n=0 between sclk edges -> frame_cnt=0, cmd_err=0, reg_addr=0, dir=1 immediately.
